// File: rtl/alu_arb_pkg.sv
// Shared definitions for the alu_share_arbiter slice: FSM state encoding,
// ALU op-code constants and default datapath widths.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Op codes understood by the external ALU. The arbiter never decodes them;
  // they are here so requesters and benches share one definition.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant. Purely combinational; the caller owns
// the pointer register. When upd_i is set the pointer moves to the requester
// that did not just finish, and that updated pointer already decides the
// grant, so a same-edge re-arbitration sees the new priority.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  input  logic       upd_i,
  input  logic       upd_owner_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  // Pointer update and grant selection.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ptr_o = ptr_i;
    gnt_o = valid_i;
    if (upd_i) begin
      ptr_o = ~upd_owner_i;
    end
    if (valid_i == 2'b11) begin
      gnt_o = ptr_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// requesters. IDLE arbitrates and latches operands, EXEC drives the ALU for
// one cycle and captures its result, RESP holds the result for the owner
// until it is taken. The round-robin pointer only moves when a response is
// consumed, so a requester that lost contention is served next.
//
// Optional build macro: ALU_ARB_BACKTOBACK_EN. When defined, arbitration also
// runs in RESP on the response-handshake edge, allowing one accept every two
// cycles. When undefined, RESP always returns to IDLE (three-cycle spacing).
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int RR_INIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_data1_i,
  input  logic [DATA_W-1:0] req0_data2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_data1_i,
  input  logic [DATA_W-1:0] req1_data2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,

  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic              rsp0_zero_o,

  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              rsp1_zero_o,

  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              alu_zero_i
);

  arb_state_e        state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;

  logic              rsp_hs;
  logic              arb_en;
  logic [1:0]        req_v;
  logic [1:0]        gnt;
  logic              rr_upd;
  logic              accept;

  // Response handshake and the window in which a new request may be granted.
  always_comb begin
    rsp_hs = (state_q == ST_RESP) & (owner_q ? rsp1_ready_i : rsp0_ready_i);
`ifdef ALU_ARB_BACKTOBACK_EN
    arb_en = (state_q == ST_IDLE) | rsp_hs;
`else
    arb_en = (state_q == ST_IDLE);
`endif
    req_v  = {req1_valid_i, req0_valid_i} & {2{arb_en}};
  end

  rr_arb2 u_rr_arb2 (
    .valid_i     (req_v),
    .ptr_i       (rr_q),
    .upd_i       (rsp_hs),
    .upd_owner_i (owner_q),
    .gnt_o       (gnt),
    .ptr_o       (rr_upd)
  );

  assign accept = |gnt;

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_upd;
    owner_d = owner_q;
    data1_d = data1_q;
    data2_d = data2_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_data_i;
        zero_d  = alu_zero_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) state_d = accept ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      owner_d = gnt[1];
      data1_d = gnt[1] ? req1_data1_i : req0_data1_i;
      data2_d = gnt[1] ? req1_data2_i : req0_data2_i;
      ctrl_d  = gnt[1] ? req1_ctrl_i  : req0_ctrl_i;
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: all registers here are plain flops, so every one is cleared on
  // reset; there is no memory array that would make this costly.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'(RR_INIT);
      owner_q <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Ready is gated by reset so nothing is acknowledged while rst_i is low.
  assign req0_ready_o = gnt[0] & rst_i;
  assign req1_ready_o = gnt[1] & rst_i;

  assign rsp0_valid_o = (state_q == ST_RESP) & ~owner_q;
  assign rsp1_valid_o = (state_q == ST_RESP) &  owner_q;
  assign rsp0_data_o  = res_q;
  assign rsp1_data_o  = res_q;
  assign rsp0_zero_o  = zero_q;
  assign rsp1_zero_o  = zero_q;

  // The ALU always sees the last latched operands, so it is quiet while idle.
  assign alu_data1_o  = data1_q;
  assign alu_data2_o  = data2_q;
  assign alu_ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of single-requester vectors plus
// hand-written sequences for contention, response stall, mid-op reset,
// idle response-ready pulses and back-to-back throughput.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

`ifdef ALU_ARB_BACKTOBACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif
  localparam int SPACING = BTB ? 2 : 3;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero;
  logic [1:0][31:0] req_d1, req_d2, rsp_data;
  logic [1:0][2:0]  req_ctrl;
  logic [31:0]      alu_d1, alu_d2, alu_res;
  logic [2:0]       alu_ctrl;
  logic             alu_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference ALU sitting outside the arbiter.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_AND:  alu_res = alu_d1 & alu_d2;
      OP_XOR:  alu_res = alu_d1 ^ alu_d2;
      OP_SLL:  alu_res = alu_d1 << alu_d2[4:0];
      OP_ADDI: alu_res = alu_d1 + alu_d2;
      OP_SUB:  alu_res = alu_d1 - alu_d2;
      OP_MUL:  alu_res = alu_d1 * alu_d2;
      OP_ADD:  alu_res = alu_d1 + alu_d2;
      OP_SRAI: alu_res = $signed(alu_d1) >>> alu_d2[4:0];
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  alu_share_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req_valid[0]),
    .req0_ready_o (req_ready[0]),
    .req0_data1_i (req_d1[0]),
    .req0_data2_i (req_d2[0]),
    .req0_ctrl_i  (req_ctrl[0]),
    .req1_valid_i (req_valid[1]),
    .req1_ready_o (req_ready[1]),
    .req1_data1_i (req_d1[1]),
    .req1_data2_i (req_d2[1]),
    .req1_ctrl_i  (req_ctrl[1]),
    .rsp0_valid_o (rsp_valid[0]),
    .rsp0_ready_i (rsp_ready[0]),
    .rsp0_data_o  (rsp_data[0]),
    .rsp0_zero_o  (rsp_zero[0]),
    .rsp1_valid_o (rsp_valid[1]),
    .rsp1_ready_i (rsp_ready[1]),
    .rsp1_data_o  (rsp_data[1]),
    .rsp1_zero_o  (rsp_zero[1]),
    .alu_data1_o  (alu_d1),
    .alu_data2_o  (alu_d2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_data_i   (alu_res),
    .alu_zero_i   (alu_zero)
  );

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_z;
    string       name;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[id] = 1'b1;
    req_ctrl[id]  = op;
    req_d1[id]    = a;
    req_d2[id]    = b;
  endtask

  // Wait (bounded) for ready on a driven request, take the accept edge,
  // drop valid and check the ALU sees the latched operands during EXEC.
  task automatic accept(input int id, input string name);
    int n = 0;
    #1;
    while (!req_ready[id] && n < 12) begin
      @(negedge clk_i); #1; n++;
    end
    check({name, ".ready"}, 32'(req_ready[id]), 32'd1);
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid[id] = 1'b0;
    #1;
    check({name, ".alu_ctrl"}, 32'(alu_ctrl), 32'(req_ctrl[id]));
    check({name, ".alu_d1"}, alu_d1, req_d1[id]);
    check({name, ".alu_d2"}, alu_d2, req_d2[id]);
  endtask

  // Wait (bounded) for the response, check it, take it. Reports whether the
  // other requester was accepted on the same edge (back-to-back build).
  task automatic wait_rsp(input int id, input logic [31:0] exp_d, input logic exp_z,
                          input string name, output bit other_acc);
    int n = 0;
    int o = 1 - id;
    #1;
    while (!rsp_valid[id] && n < 12) begin
      @(negedge clk_i); #1; n++;
    end
    check({name, ".rsp_valid"}, 32'(rsp_valid[id]), 32'd1);
    check({name, ".data"}, rsp_data[id], exp_d);
    check({name, ".zero"}, 32'(rsp_zero[id]), 32'(exp_z));
    check({name, ".other_valid"}, 32'(rsp_valid[o]), 32'd0);
    rsp_ready[id] = 1'b1;
    #1;
    other_acc = req_valid[o] & req_ready[o];
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready[id] = 1'b0;
    if (other_acc) req_valid[o] = 1'b0;
    #1;
    check({name, ".rsp_done"}, 32'(rsp_valid[id]), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    #1;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] b_a [4];
    logic [31:0] b_b [4];
    logic [31:0] b_exp [4];
    int b_acc [4];
    int got;

    vecs[0] = '{0, OP_SUB,  32'd5,        32'd5,        32'd0,        1'b1, "sub_zero"};
    vecs[1] = '{0, OP_XOR,  32'h0000_00AA, 32'h0000_0055, 32'h0000_00FF, 1'b0, "xor"};
    vecs[2] = '{0, OP_SLL,  32'd1,        32'd4,        32'h0000_0010, 1'b0, "sll"};
    vecs[3] = '{1, OP_ADDI, 32'd10,       32'hFFFF_FFFD, 32'd7,        1'b0, "addi_neg"};
    vecs[4] = '{0, OP_ADD,  32'hFFFF_FFFF, 32'd1,        32'd0,        1'b1, "add_wrap"};
    vecs[5] = '{1, OP_SRAI, 32'h8000_0000, 32'd4,        32'hF800_0000, 1'b0, "srai_sign"};
    vecs[6] = '{1, OP_AND,  32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, "and"};
    vecs[7] = '{1, OP_MUL,  32'd6,        32'd7,        32'd42,       1'b0, "mul"};
    vecs[8] = '{0, OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'd0,       1'b1, "mul_ovf"};

    b_a   = '{32'h0000_00AA, 32'h0000_00FF, 32'h0000_1234, 32'h0000_0000};
    b_b   = '{32'h0000_0055, 32'h0000_000F, 32'h0000_1234, 32'hFFFF_FFFF};
    b_exp = '{32'h0000_00FF, 32'h0000_00F0, 32'h0000_0000, 32'hFFFF_FFFF};

    req_valid = '0;
    rsp_ready = '0;
    req_d1    = '0;
    req_d2    = '0;
    req_ctrl  = '0;

    // Reset state, with a request pending that must not be acknowledged.
    @(negedge clk_i);
    drive(0, OP_ADD, 32'd1, 32'd2);
    #1;
    check("rst.ready0", 32'(req_ready[0]), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.alu_d1", alu_d1, 32'd0);
    check("rst.alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst.rsp_data", rsp_data[0], 32'd0);
    req_valid = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;

    // Single-requester vectors.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      drive(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      accept(vecs[i].id, vecs[i].name);
      wait_rsp(vecs[i].id, vecs[i].exp_d, vecs[i].exp_z, vecs[i].name, acc);
    end

    // Contention: pointer starts at 0, then toggles after each response.
    reset_dut();
    drive(0, OP_ADD, 32'd3, 32'd4);
    drive(1, OP_MUL, 32'd6, 32'd7);
    #1;
    check("cont.ready0", 32'(req_ready[0]), 32'd1);
    check("cont.ready1", 32'(req_ready[1]), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid[0] = 1'b0;
    #1;
    check("cont.exec_ready1", 32'(req_ready[1]), 32'd0);
    check("cont.exec_ctrl", 32'(alu_ctrl), 32'(OP_ADD));
    wait_rsp(0, 32'd7, 1'b0, "cont.r0", acc);
    check("cont.b2b_r1", 32'(acc), 32'(BTB));
    if (!acc) accept(1, "cont.a1");
    wait_rsp(1, 32'd42, 1'b0, "cont.r1", acc);
    drive(0, OP_SUB, 32'd9, 32'd4);
    drive(1, OP_ADD, 32'd1, 32'd1);
    #1;
    check("cont2.ready0", 32'(req_ready[0]), 32'd1);
    check("cont2.ready1", 32'(req_ready[1]), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid[0] = 1'b0;
    wait_rsp(0, 32'd5, 1'b0, "cont2.r0", acc);
    if (!acc) accept(1, "cont2.a1");
    wait_rsp(1, 32'd2, 1'b0, "cont2.r1", acc);

    // Response stall: rsp1 held for 5 cycles while req0 waits.
    reset_dut();
    drive(1, OP_SRAI, 32'hFFFF_FFF8, 32'd1);
    accept(1, "stall.a1");
    drive(0, OP_XOR, 32'd1, 32'd3);
    #1;
    check("stall.exec_ready0", 32'(req_ready[0]), 32'd0);
    @(negedge clk_i);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall.hold%0d_valid", i), 32'(rsp_valid[1]), 32'd1);
      check($sformatf("stall.hold%0d_data", i), rsp_data[1], 32'hFFFF_FFFC);
      check($sformatf("stall.hold%0d_ready0", i), 32'(req_ready[0]), 32'd0);
      @(negedge clk_i);
      #1;
    end
    wait_rsp(1, 32'hFFFF_FFFC, 1'b0, "stall.r1", acc);
    check("stall.b2b_r0", 32'(acc), 32'(BTB));
    if (!acc) accept(0, "stall.a0");
    wait_rsp(0, 32'd2, 1'b0, "stall.r0", acc);

    // Reset during EXEC discards the operation.
    reset_dut();
    drive(0, OP_AND, 32'h0000_00F0, 32'h0000_003C);
    accept(0, "rstx.a0");
    req_valid[0] = 1'b1;
    rst_i = 1'b0;
    #1;
    check("rstx.ready0", 32'(req_ready[0]), 32'd0);
    check("rstx.ready1", 32'(req_ready[1]), 32'd0);
    check("rstx.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstx.alu_d1", alu_d1, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    req_valid[0] = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rstx.no_rsp%0d", i), 32'(rsp_valid), 32'd0);
      @(negedge clk_i);
      #1;
    end
    drive(0, OP_AND, 32'h0000_00F0, 32'h0000_003C);
    accept(0, "rstx.again");
    wait_rsp(0, 32'h0000_0030, 1'b0, "rstx.r0", acc);

    // Response ready pulsed while idle: ignored.
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      #1;
      check($sformatf("idle.rsp_valid%0d", i), 32'(rsp_valid), 32'd0);
      check($sformatf("idle.req_ready%0d", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b00;
    @(negedge clk_i);
    drive(1, OP_ADD, 32'd2, 32'd2);
    accept(1, "idle.a1");
    wait_rsp(1, 32'd4, 1'b0, "idle.r1", acc);

    // Back-to-back XORs with rsp0_ready tied high.
    reset_dut();
    rsp_ready[0] = 1'b1;
    got = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int n = 0;
          drive(0, OP_XOR, b_a[k], b_b[k]);
          #1;
          while (!req_ready[0] && n < 12) begin
            @(negedge clk_i); #1; n++;
          end
          check($sformatf("b2b.ready%0d", k), 32'(req_ready[0]), 32'd1);
          b_acc[k] = cyc;
          @(negedge clk_i);
        end
        req_valid[0] = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk_i);
          #2;
          if (rsp_valid[0]) begin
            if (got < 4) check($sformatf("b2b.data%0d", got), rsp_data[0], b_exp[got]);
            got++;
          end
        end
      end
    join
    rsp_ready[0] = 1'b0;
    check("b2b.count", 32'(got), 32'd4);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("b2b.spacing%0d", k), 32'(b_acc[k] - b_acc[k-1]), 32'(SPACING));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
